fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
- Writer side of the FIR tap coefficient interface: accepts a serial stream of tap coefficients over a valid/ready handshake.
- Stores the stream into a shadow bank, then swaps it atomically into the active bank on a sample strobe.
- Active bank drives the h inputs of the tap chain, so coefficients never change mid-sample.
- Sits between the control/UI logic and the filter tap chain.

Parameters:
NTAPS, 16, number of filter taps / coefficients per load (2..64)
COEF_W, 16, coefficient width, signed two's complement
IDX_W, 4, width of index counter, must equal clog2(NTAPS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
load_start  in  1  one-cycle pulse: begin (or restart) a coefficient load
coef_valid  in  1  coef_data valid
coef_data  in  COEF_W  coefficient, first beat = tap 0
coef_ready  out  1  loader accepts coef_data this cycle
sample_strobe  in  1  one-cycle pulse per audio sample (same clock domain)
h_active  out  NTAPS*COEF_W  active bank, tap k at bits [k*COEF_W +: COEF_W]
busy  out  1  high in LOAD or WAIT_SWAP
swap_done  out  1  one-cycle pulse, cycle after the active bank updates
load_idx  out  IDX_W  index of next coefficient to be written

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - Shadow and active banks all zero (filter outputs silence).
  - load_idx=0, coef_ready=0, busy=0, swap_done=0.
- Handshake: a beat transfers when coef_valid & coef_ready on a rising clk edge. coef_ready is registered-state decoded: 1 iff state==LOAD.
- IDLE:
  - coef_ready=0.
  - load_start -> LOAD, load_idx<=0.
  - coef_valid ignored, data dropped.
- LOAD:
  - Each transfer writes shadow[load_idx]<=coef_data and increments load_idx.
  - Transfer with load_idx==NTAPS-1 -> WAIT_SWAP, load_idx<=0 (wraps).
  - load_start in LOAD restarts: load_idx<=0, stays in LOAD, no write that cycle even if a beat is offered. Shadow contents are partially stale until overwritten.
  - sample_strobe has no effect in LOAD.
- WAIT_SWAP:
  - coef_ready=0.
  - On sample_strobe: active<=shadow (all taps in one edge), -> IDLE, swap_done=1 next cycle.
  - load_start in WAIT_SWAP: pending swap cancelled, -> LOAD, load_idx<=0. Active bank is untouched.
  - If load_start and sample_strobe arrive in the same cycle, load_start wins: no swap.
- Last beat coincident with sample_strobe: that strobe is not used. The swap occurs on the next strobe, giving a minimum one-cycle gap between last beat and swap.
- Active bank changes only on a swap edge; never partially updated.
- busy = (state!=IDLE).
- Latency:
  - Last accepted beat to WAIT_SWAP: 1 cycle.
  - Strobe to h_active valid: 1 cycle.
  - Strobe to swap_done: 2 cycles.
- Reset mid-load or mid-wait: everything cleared to the reset state immediately. The active bank returns to zero, not the previous set.
- No arithmetic on coefficients; values pass through bit-exact.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=2'd0, LOAD=2'd1, WAIT_SWAP=2'd2.
  - COEF_W default (16), shared with the tap chain.
  - NTAPS default.
- One natural sub-module, coeff_bank: a NTAPS x COEF_W register array with indexed write port, bulk-copy enable, async clear and flattened output. Instantiate it twice (shadow, active), or once with an internal shadow/active pair.
- FSM, index counter and handshake stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release -> h_active==0, coef_ready=0, busy=0. coef_valid=1 with data 16'h1234 in IDLE -> no change.
- Normal load: load_start, then 16 beats k -> 16'h0100+k with valid held high. Expect:
  - coef_ready high 16 cycles, load_idx counts 0..15, busy=1.
  - h_active unchanged until sample_strobe.
  - Next cycle h_active tap k == 16'h0100+k; swap_done pulses the following cycle.
- Backpressure/gaps: valid toggled 1-0-1 randomly during load -> only beats with valid&ready are written, in order. Final tap 15 == last valid beat.
- Restart mid-load: load 5 beats (16'hAAAA), load_start, then 16 beats of 16'h5555, then strobe -> all taps 16'h5555. In the restart cycle no write occurs.
- Cancel in WAIT_SWAP: load 16 beats of 16'h7FFF, then load_start and sample_strobe in the same cycle -> no swap, state LOAD, h_active keeps its prior value.
- Last beat coincident with sample_strobe: -> no swap that cycle. The next strobe swaps. Reset asserted in WAIT_SWAP -> h_active==0 asynchronously.

Source files
------------

// File: rtl/fir_coeff_loader_pkg.sv
// Shared definitions for the FIR coefficient loader and the tap chain.
//   - FSM state encoding (kept as plain 2-bit constants for legacy users)
//   - Default tap count, coefficient width and index width
package fir_coeff_loader_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_SWAP = 2'd2;

  localparam int FIR_NTAPS  = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_IDX_W  = 4;

endpackage

// File: rtl/fir_coeff_loader_coeff_bank.sv
// coeff_bank: NTAPS x COEF_W coefficient register array.
// Ports:
//   clk, rst   - clock, asynchronous active-high clear (all taps to zero)
//   wr_en      - write wr_data into tap wr_idx
//   wr_idx     - tap index for the single-entry write
//   wr_data    - signed coefficient to write
//   copy_en    - load every tap from copy_data in one edge (wins over wr_en)
//   copy_data  - flattened source bank, tap k at [k*COEF_W +: COEF_W]
//   q          - flattened bank contents, tap k at [k*COEF_W +: COEF_W]
module coeff_bank
  import fir_coeff_loader_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int COEF_W = FIR_COEF_W,
  parameter int IDX_W  = FIR_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic signed [COEF_W-1:0]  wr_data,
  input  logic                      copy_en,
  input  logic [NTAPS*COEF_W-1:0]   copy_data,
  output logic [NTAPS*COEF_W-1:0]   q
);

  logic signed [COEF_W-1:0] bank [NTAPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) bank[k] <= '0;
    end else if (copy_en) begin
      for (int k = 0; k < NTAPS; k++) bank[k] <= copy_data[k*COEF_W +: COEF_W];
    end else if (wr_en) begin
      for (int k = 0; k < NTAPS; k++)
        if (wr_idx == IDX_W'(k)) bank[k] <= wr_data;
    end
  end

  always_comb begin
    q = '0;
    for (int k = 0; k < NTAPS; k++) q[k*COEF_W +: COEF_W] = bank[k];
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: writer side of the FIR tap coefficient interface.
// A serial coefficient stream (valid/ready) fills a shadow bank; on a sample
// strobe the whole shadow bank is copied into the active bank in one edge,
// so the tap chain never sees a half-updated coefficient set.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   load_start     - pulse: begin or restart a load (cancels a pending swap)
//   coef_valid     - coef_data valid
//   coef_data      - signed coefficient, first beat is tap 0
//   coef_ready     - high while loading (state LOAD)
//   sample_strobe  - pulse once per audio sample
//   h_active       - active bank, tap k at [k*COEF_W +: COEF_W]
//   busy           - load or swap pending
//   swap_done      - pulse the cycle after the active bank updates
//   load_idx       - index of the next coefficient to be written
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int COEF_W = FIR_COEF_W,
  parameter int IDX_W  = FIR_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      coef_valid,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      coef_ready,
  input  logic                      sample_strobe,
  output logic [NTAPS*COEF_W-1:0]   h_active,
  output logic                      busy,
  output logic                      swap_done,
  output logic [IDX_W-1:0]          load_idx
);

  logic [1:0]                state;
  logic                      beat;
  logic                      swap_en;
  logic                      swap_p0;
  logic [NTAPS*COEF_W-1:0]   h_shadow;

  assign coef_ready = (state == LOAD);
  assign busy       = (state != IDLE);

  // A restart pulse suppresses any beat offered in the same cycle.
  assign beat    = coef_valid & coef_ready & ~load_start;
  // load_start beats a coincident strobe: the pending swap is abandoned.
  assign swap_en = (state == WAIT_SWAP) & sample_strobe & ~load_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            load_idx <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            load_idx <= '0;
          end else if (beat) begin
            if (load_idx == IDX_W'(NTAPS - 1)) begin
              state    <= WAIT_SWAP;
              load_idx <= '0;
            end else begin
              load_idx <= load_idx + IDX_W'(1);
            end
          end
        end
        WAIT_SWAP: begin
          if (load_start) begin
            state    <= LOAD;
            load_idx <= '0;
          end else if (swap_en) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          load_idx <= '0;
        end
      endcase
    end
  end

  // Stage p0: active bank copied on this edge; swap_done follows one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_p0   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_p0   <= swap_en;
      swap_done <= swap_p0;
    end
  end

  coeff_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (beat),
    .wr_idx    (load_idx),
    .wr_data   (coef_data),
    .copy_en   (1'b0),
    .copy_data ('0),
    .q         (h_shadow)
  );

  coeff_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) u_active (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .copy_en   (swap_en),
    .copy_data (h_shadow),
    .q         (h_active)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

  localparam int NTAPS  = 16;
  localparam int COEF_W = 16;
  localparam int IDX_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     load_start;
  logic                     coef_valid;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_ready;
  logic                     sample_strobe;
  logic [NTAPS*COEF_W-1:0]  h_active;
  logic                     busy;
  logic                     swap_done;
  logic [IDX_W-1:0]         load_idx;

  int vectors     = 0;
  int miscompares = 0;
  logic [NTAPS*COEF_W-1:0] exp_h;
  logic [NTAPS*COEF_W-1:0] new_h;

  fir_coeff_loader #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .coef_valid    (coef_valid),
    .coef_data     (coef_data),
    .coef_ready    (coef_ready),
    .sample_strobe (sample_strobe),
    .h_active      (h_active),
    .busy          (busy),
    .swap_done     (swap_done),
    .load_idx      (load_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [COEF_W-1:0] d);
    coef_valid = 1'b1;
    coef_data  = d;
    tick();
    coef_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; coef_valid = 1'b0;
    coef_data = '0; sample_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (h_active !== '0) begin miscompares++; $display("FAIL reset_h_active: got %h want 0", h_active); end
    vectors++; if (coef_ready !== 1'b0) begin miscompares++; $display("FAIL reset_coef_ready: got %b want 0", coef_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL reset_swap_done: got %b want 0", swap_done); end
    vectors++; if (load_idx !== 4'd0) begin miscompares++; $display("FAIL reset_load_idx: got %0d want 0", load_idx); end
    rst = 1'b0;
    coef_valid = 1'b1; coef_data = 16'h1234;
    repeat (3) tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0; coef_valid = 1'b0;
    tick();
    vectors++; if (h_active !== '0) begin miscompares++; $display("FAIL idle_h_active: got %h want 0", h_active); end
    vectors++; if (coef_ready !== 1'b0) begin miscompares++; $display("FAIL idle_coef_ready: got %b want 0", coef_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    vectors++; if (load_idx !== 4'd0) begin miscompares++; $display("FAIL idle_load_idx: got %0d want 0", load_idx); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL idle_swap_done: got %b want 0", swap_done); end
  endtask

  task automatic test_normal_load();
    pulse_start();
    vectors++; if (coef_ready !== 1'b1) begin miscompares++; $display("FAIL load_ready: got %b want 1", coef_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b want 1", busy); end
    for (int k = 0; k < NTAPS; k++) begin
      vectors++; if (load_idx !== IDX_W'(k) || coef_ready !== 1'b1) begin miscompares++; $display("FAIL load_idx_count: got idx %0d ready %b want idx %0d ready 1", load_idx, coef_ready, k); end
      send_beat(16'(16'h0100 + k));
    end
    vectors++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL wait_state: got ready %b busy %b want 0 1", coef_ready, busy); end
    vectors++; if (load_idx !== 4'd0) begin miscompares++; $display("FAIL wait_load_idx: got %0d want 0", load_idx); end
    repeat (3) tick();
    vectors++; if (h_active !== '0) begin miscompares++; $display("FAIL pre_swap_h_active: got %h want 0", h_active); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int k = 0; k < NTAPS; k++) exp_h[k*COEF_W +: COEF_W] = 16'(16'h0100 + k);
    vectors++; if (h_active !== exp_h) begin miscompares++; $display("FAIL swap_h_active: got %h want %h", h_active, exp_h); end
    vectors++; if (swap_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL swap_early: got swap_done %b busy %b want 0 0", swap_done, busy); end
    tick();
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL swap_done_pulse: got %b want 1", swap_done); end
    tick();
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL swap_done_end: got %b want 0", swap_done); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    logic        v;
    int beats;
    int cyc;
    pat = 32'hB6D3_AD97;
    beats = 0;
    cyc = 0;
    new_h = exp_h;
    pulse_start();
    while (beats < NTAPS && cyc < 100) begin
      v = pat[cyc % 32];
      coef_valid = v;
      coef_data  = 16'(16'h2000 + cyc);
      vectors++; if (load_idx !== IDX_W'(beats)) begin miscompares++; $display("FAIL gap_load_idx: got %0d want %0d", load_idx, beats); end
      if (v) new_h[beats*COEF_W +: COEF_W] = 16'(16'h2000 + cyc);
      tick();
      if (v) beats++;
      cyc++;
    end
    coef_valid = 1'b0;
    vectors++; if (cyc >= 100) begin miscompares++; $display("FAIL gap_timeout: got %0d beats want %0d", beats, NTAPS); end
    vectors++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL gap_wait_state: got ready %b busy %b want 0 1", coef_ready, busy); end
    vectors++; if (h_active !== exp_h) begin miscompares++; $display("FAIL gap_pre_swap: got %h want %h", h_active, exp_h); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    exp_h = new_h;
    vectors++; if (h_active !== exp_h) begin miscompares++; $display("FAIL gap_h_active: got %h want %h", h_active, exp_h); end
    tick();
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL gap_swap_done: got %b want 1", swap_done); end
  endtask

  task automatic test_restart();
    pulse_start();
    repeat (5) send_beat(16'hAAAA);
    vectors++; if (load_idx !== 4'd5) begin miscompares++; $display("FAIL restart_pre_idx: got %0d want 5", load_idx); end
    load_start = 1'b1; coef_valid = 1'b1; coef_data = 16'h1111;
    tick();
    load_start = 1'b0; coef_valid = 1'b0;
    vectors++; if (load_idx !== 4'd0 || coef_ready !== 1'b1) begin miscompares++; $display("FAIL restart_idx: got idx %0d ready %b want 0 1", load_idx, coef_ready); end
    repeat (NTAPS) send_beat(16'h5555);
    vectors++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL restart_wait: got ready %b busy %b want 0 1", coef_ready, busy); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int k = 0; k < NTAPS; k++) exp_h[k*COEF_W +: COEF_W] = 16'h5555;
    vectors++; if (h_active !== exp_h) begin miscompares++; $display("FAIL restart_h_active: got %h want %h", h_active, exp_h); end
    tick();
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL restart_swap_done: got %b want 1", swap_done); end
  endtask

  task automatic test_cancel();
    pulse_start();
    repeat (NTAPS) send_beat(16'h7FFF);
    vectors++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL cancel_wait: got ready %b busy %b want 0 1", coef_ready, busy); end
    load_start = 1'b1; sample_strobe = 1'b1;
    tick();
    load_start = 1'b0; sample_strobe = 1'b0;
    vectors++; if (coef_ready !== 1'b1 || load_idx !== 4'd0) begin miscompares++; $display("FAIL cancel_state: got ready %b idx %0d want 1 0", coef_ready, load_idx); end
    vectors++; if (h_active !== exp_h) begin miscompares++; $display("FAIL cancel_h_active: got %h want %h", h_active, exp_h); end
    tick();
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL cancel_swap_done: got %b want 0", swap_done); end
  endtask

  task automatic test_coincident();
    // Continues in LOAD left by test_cancel.
    for (int k = 0; k < NTAPS - 1; k++) send_beat(16'(16'h8000 + k));
    coef_valid = 1'b1; coef_data = 16'h800F; sample_strobe = 1'b1;
    tick();
    coef_valid = 1'b0; sample_strobe = 1'b0;
    vectors++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL coinc_wait: got ready %b busy %b want 0 1", coef_ready, busy); end
    vectors++; if (h_active !== exp_h) begin miscompares++; $display("FAIL coinc_no_swap: got %h want %h", h_active, exp_h); end
    tick(); tick();
    vectors++; if (swap_done !== 1'b0 || h_active !== exp_h) begin miscompares++; $display("FAIL coinc_late_swap: got swap_done %b h %h want 0 %h", swap_done, h_active, exp_h); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int k = 0; k < NTAPS; k++) exp_h[k*COEF_W +: COEF_W] = 16'(16'h8000 + k);
    vectors++; if (h_active !== exp_h || busy !== 1'b0) begin miscompares++; $display("FAIL coinc_swap: got h %h busy %b want %h 0", h_active, busy, exp_h); end
    tick();
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL coinc_swap_done: got %b want 1", swap_done); end
  endtask

  task automatic test_reset_wait();
    pulse_start();
    repeat (NTAPS) send_beat(16'h0F0F);
    vectors++; if (busy !== 1'b1 || h_active !== exp_h) begin miscompares++; $display("FAIL rw_pre: got busy %b h %h want 1 %h", busy, h_active, exp_h); end
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (h_active !== '0) begin miscompares++; $display("FAIL rw_h_active: got %h want 0", h_active); end
    vectors++; if (busy !== 1'b0 || coef_ready !== 1'b0 || load_idx !== 4'd0) begin miscompares++; $display("FAIL rw_ctrl: got busy %b ready %b idx %0d want 0 0 0", busy, coef_ready, load_idx); end
    tick();
    rst = 1'b0;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    vectors++; if (h_active !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL rw_after: got h %h busy %b want 0 0", h_active, busy); end
  endtask

  initial begin
    exp_h = '0;
    test_reset();
    test_normal_load();
    test_backpressure();
    test_restart();
    test_cancel();
    test_coincident();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
